// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter slice:
//   - state_t : sequencer state encoding (IDLE -> ISSUE -> WAIT -> RESP)
//   - PORT0/PORT1 : requester identifiers as stored in the port latch and in
//     the round-robin last-grant pointer
//   - DEF_* : default address/data widths and memory latency
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_MEM_LAT = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester handshakes, their response channels and the
// memory-side strobe bus of the data-memory arbiter.
//   slave  : the arbiter's view (takes requests, drives responses and memory)
//   master : the environment's view (requesters plus the memory itself)
// Signals:
//   reqN_valid/ready/we/addr/wdata : request handshake and payload, port N
//   rspN_valid/rdata               : one-cycle response pulse and data, port N
//   mem_addr/wdata/read/write      : to memory
//   mem_rdata                      : from memory
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker. The grant is purely combinational from the
// request vector and a registered last-grant pointer; the pointer moves only
// when the caller signals that the grant was consumed (advance).
// Ports:
//   clk     : clock
//   rst_n   : synchronous active-low reset (pointer set so port 0 wins first)
//   req     : request vector, bit N = port N
//   advance : the current grant was taken this cycle
//   grant   : one-hot (or zero) grant vector
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_reg;
    logic last_next;

    // With a single requester it simply wins; with both, the one that was
    // not served last wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_reg == PORT0) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        last_next = last_reg;
        if (advance && (grant != 2'b00)) begin
            last_next = grant[1] ? PORT1 : PORT0;
        end
    end

    // Resetting to "port 1 served last" makes port 0 the first winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_reg <= PORT1;
        end else begin
            last_reg <= last_next;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Round-robin arbiter and sequencer between two requesters (port 0: pipeline
// load/store unit, port 1: debug/DMA master) and a 32 x 64-bit data memory
// with level-sensitive MemRead/MemWrite strobes.
//
// Each accepted request walks IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP:
// the strobe is high for exactly the ISSUE cycle, read data is sampled in the
// last WAIT cycle and a one-cycle response pulse goes back to the requester
// that issued the access in RESP.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset; drops any in-flight access
//   bus   : dmem_arbiter_if.slave - request/response channels and memory bus
// Parameters:
//   ADDR_W, DATA_W : address/data widths
//   MEM_LAT        : cycles (>=1) from the strobe cycle to the sample cycle
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    // ------------------------------------------------------------------
    // State and latches
    // ------------------------------------------------------------------
    state_t             state_reg;
    state_t             state_next;
    logic               port_reg;
    logic               we_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]  cap_reg;

    // ------------------------------------------------------------------
    // Arbitration and acceptance
    // ------------------------------------------------------------------
    logic [1:0]         valid_vec;
    logic [1:0]         grant;
    logic [1:0]         ready_vec;
    logic               in_idle;
    logic               transfer;
    logic               sel_port;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    assign valid_vec = {bus.req1_valid, bus.req0_valid};

    // Ready is gated by rst_n so that nothing is accepted, and every output
    // reads 0, for as long as reset is held.
    assign in_idle   = (state_reg == IDLE) && rst_n;
    assign ready_vec = grant & {2{in_idle}};
    // grant is a subset of valid_vec, so any ready bit implies a handshake.
    assign transfer  = |ready_vec;
    assign sel_port  = ready_vec[1] ? PORT1 : PORT0;

    assign sel_we    = (sel_port == PORT1) ? bus.req1_we    : bus.req0_we;
    assign sel_addr  = (sel_port == PORT1) ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = (sel_port == PORT1) ? bus.req1_wdata : bus.req0_wdata;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (valid_vec),
        .advance (transfer),
        .grant   (grant)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM: next state and strobes
    // ------------------------------------------------------------------
    logic wait_last;
    logic rd_strobe;
    logic wr_strobe;

    assign wait_last = (state_reg == WAIT) && (cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        rd_strobe  = 1'b0;
        wr_strobe  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (transfer) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // The only cycle a strobe is high, so strobes always fall
                // between accesses and never overlap.
                rd_strobe  = !we_reg;
                wr_strobe  = we_reg;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Request latches, latency counter and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            port_reg  <= PORT0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            cnt_reg   <= '0;
            cap_reg   <= '0;
        end else begin
            if (transfer) begin
                port_reg  <= sel_port;
                we_reg    <= sel_we;
                addr_reg  <= sel_addr;
                wdata_reg <= sel_wdata;
            end
            // Load on the way into WAIT so WAIT lasts exactly MEM_LAT cycles.
            if (state_reg == ISSUE) begin
                cnt_reg <= CNT_W'(MEM_LAT - 1);
            end else if ((state_reg == WAIT) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
            if (wait_last && !we_reg) begin
                cap_reg <= bus.mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-port response channels
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]       resp_data;
    logic [1:0]              rsp_valid_vec;
    logic [1:0][DATA_W-1:0]  rsp_rdata_vec;

    assign resp_data = we_reg ? '0 : cap_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            logic              fire;
            logic [DATA_W-1:0] hold_reg;

            assign fire = (state_reg == RESP) && (port_reg == 1'(gi));

            // hold_reg keeps the last delivered value so rdata stays put after
            // the pulse; during the pulse the fresh value is shown directly.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hold_reg <= '0;
                end else if (fire) begin
                    hold_reg <= resp_data;
                end
            end

            assign rsp_valid_vec[gi] = fire;
            assign rsp_rdata_vec[gi] = fire ? resp_data : hold_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------
    assign bus.req0_ready = ready_vec[0];
    assign bus.req1_ready = ready_vec[1];
    assign bus.rsp0_valid = rsp_valid_vec[0];
    assign bus.rsp1_valid = rsp_valid_vec[1];
    assign bus.rsp0_rdata = rsp_rdata_vec[0];
    assign bus.rsp1_rdata = rsp_rdata_vec[1];

    // Address/data come straight from the latches so they hold through WAIT
    // and stay at their last value while idle.
    assign bus.mem_addr   = addr_reg;
    assign bus.mem_wdata  = wdata_reg;
    assign bus.mem_read   = rd_strobe;
    assign bus.mem_write  = wr_strobe;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Scoreboard bench for dmem_arbiter: a MEM_LAT=1 instance with a behavioural
// memory, and a MEM_LAT=3 instance for the longer-latency read path.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;
    localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory models: data is only valid in the cycle exactly MEM_LAT after
    // the strobe, so an early or late sample picks up JUNK.
    // ------------------------------------------------------------------
    logic [63:0] mem    [32];
    logic [63:0] shadow [32];
    int          since0 = 0;
    logic [4:0]  raddr0 = '0;
    int          since3 = 0;
    logic [4:0]  raddr3 = '0;

    always @(posedge clk) begin
        if (bus0.mem_write) mem[bus0.mem_addr[4:0]] <= bus0.mem_wdata;
        if (bus0.mem_read) begin
            since0 <= 1;
            raddr0 <= bus0.mem_addr[4:0];
        end else if (since0 != 0 && since0 < 1000) begin
            since0 <= since0 + 1;
        end
        if (bus3.mem_read) begin
            since3 <= 1;
            raddr3 <= bus3.mem_addr[4:0];
        end else if (since3 != 0 && since3 < 1000) begin
            since3 <= since3 + 1;
        end
    end

    assign bus0.mem_rdata = (since0 == LAT)  ? mem[raddr0] : JUNK;
    assign bus3.mem_rdata = (since3 == LAT3) ? {32'hC0DE_0000, 27'd0, raddr3} : JUNK;

    // ------------------------------------------------------------------
    // Scoreboard / monitor for the MEM_LAT=1 instance (sampled on negedge)
    // ------------------------------------------------------------------
    typedef struct {
        logic        port;
        logic [63:0] data;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] hold_exp0 = '0;
    logic [63:0] hold_exp1 = '0;
    logic        tb_last   = 1'b1;
    logic        prev_strobe = 1'b0;
    bit          have_acc  = 0;
    int          last_acc_cyc = 0;
    logic        last_acc_we  = 1'b0;
    logic [63:0] last_acc_addr = '0;
    int          acc_count = 0;
    int          wr_edges  = 0;
    int          rd_strobes = 0;
    logic        acc_ports[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            hold_exp0   = '0;
            hold_exp1   = '0;
            tb_last     = 1'b1;
            prev_strobe = 1'b0;
            have_acc    = 0;
        end else begin
            // ---- acceptance ----
            if (bus0.req0_ready || bus0.req1_ready) begin
                logic        p, we, exp_p;
                logic [63:0] a, d;
                exp_t        e;
                chk("ready_onehot", 64'(bus0.req0_ready & bus0.req1_ready), 64'd0);
                p  = bus0.req1_ready;
                chk("ready_needs_valid", 64'(p ? bus0.req1_valid : bus0.req0_valid), 64'd1);
                exp_p = (bus0.req0_valid && bus0.req1_valid) ? ~tb_last : bus0.req1_valid;
                chk("grant", 64'(p), 64'(exp_p));
                if (have_acc) chk("accept_gap", 64'((cyc - last_acc_cyc) >= 3 + LAT), 64'd1);
                we = p ? bus0.req1_we    : bus0.req0_we;
                a  = p ? bus0.req1_addr  : bus0.req0_addr;
                d  = p ? bus0.req1_wdata : bus0.req0_wdata;
                e.port    = p;
                e.data    = we ? 64'd0 : shadow[a[4:0]];
                e.acc_cyc = cyc;
                sb.push_back(e);
                if (we) shadow[a[4:0]] = d;
                tb_last       = p;
                have_acc      = 1;
                last_acc_cyc  = cyc;
                last_acc_we   = we;
                last_acc_addr = a;
                acc_count++;
                acc_ports.push_back(p);
                $display("[TB] accept port=%0d we=%0d addr=%0h wdata=%h cycle=%0d", p, we, a, d, cyc);
            end
            // ---- strobes ----
            if (bus0.mem_read || bus0.mem_write) begin
                chk("strobe_excl", 64'(bus0.mem_read & bus0.mem_write), 64'd0);
                chk("strobe_gap", 64'(prev_strobe), 64'd0);
                chk("strobe_lat", 64'(cyc - last_acc_cyc), 64'd1);
                chk("strobe_type", 64'(bus0.mem_write), 64'(last_acc_we));
                chk("strobe_addr", bus0.mem_addr, last_acc_addr);
                if (bus0.mem_write && !prev_strobe) wr_edges++;
                if (bus0.mem_read) rd_strobes++;
            end
            prev_strobe = bus0.mem_read | bus0.mem_write;
            // ---- responses ----
            if (bus0.rsp0_valid || bus0.rsp1_valid) begin
                chk("rsp_onehot", 64'(bus0.rsp0_valid & bus0.rsp1_valid), 64'd0);
                chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t        e;
                    logic [63:0] got;
                    e   = sb.pop_front();
                    got = bus0.rsp1_valid ? bus0.rsp1_rdata : bus0.rsp0_rdata;
                    chk("rsp_port", 64'(bus0.rsp1_valid), 64'(e.port));
                    chk("rsp_data", got, e.data);
                    chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(2 + LAT));
                    if (e.port) hold_exp1 = e.data;
                    else        hold_exp0 = e.data;
                    $display("[TB] rsp port=%0d rdata=%h cycle=%0d", bus0.rsp1_valid, got, cyc);
                end
            end
            if (!bus0.rsp0_valid) chk("rsp0_hold", bus0.rsp0_rdata, hold_exp0);
            if (!bus0.rsp1_valid) chk("rsp1_hold", bus0.rsp1_rdata, hold_exp1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic p, input logic v, input logic we,
                         input logic [63:0] a, input logic [63:0] d);
        if (p) begin
            bus0.req1_valid = v; bus0.req1_we = we; bus0.req1_addr = a; bus0.req1_wdata = d;
        end else begin
            bus0.req0_valid = v; bus0.req0_we = we; bus0.req0_addr = a; bus0.req0_wdata = d;
        end
    endtask

    task automatic send(input logic p, input logic we, input logic [63:0] a, input logic [63:0] d);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        drive(p, 1'b1, we, a, d);
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = p ? bus0.req1_ready : bus0.req0_ready;
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk); #1;
        if (p) bus0.req1_valid = 1'b0;
        else   bus0.req0_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_req0_ready"}, 64'(bus0.req0_ready), 64'd0);
        chk({pfx, "_req1_ready"}, 64'(bus0.req1_ready), 64'd0);
        chk({pfx, "_rsp0_valid"}, 64'(bus0.rsp0_valid), 64'd0);
        chk({pfx, "_rsp1_valid"}, 64'(bus0.rsp1_valid), 64'd0);
        chk({pfx, "_rsp0_rdata"}, bus0.rsp0_rdata, 64'd0);
        chk({pfx, "_rsp1_rdata"}, bus0.rsp1_rdata, 64'd0);
        chk({pfx, "_mem_addr"},   bus0.mem_addr, 64'd0);
        chk({pfx, "_mem_wdata"},  bus0.mem_wdata, 64'd0);
        chk({pfx, "_mem_read"},   64'(bus0.mem_read), 64'd0);
        chk({pfx, "_mem_write"},  64'(bus0.mem_write), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int w0, r0, a0, t3;
        logic ok;

        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        bus3.req0_valid = 1'b0; bus3.req0_we = 1'b0; bus3.req0_addr = '0; bus3.req0_wdata = '0;
        bus3.req1_valid = 1'b0; bus3.req1_we = 1'b0; bus3.req1_addr = '0; bus3.req1_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i]    = 64'h1000 + 64'(i);
            shadow[i] = 64'h1000 + 64'(i);
        end
        mem[3]    = 64'd5;
        shadow[3] = 64'd5;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Single read of word 3 on port 0
        send(1'b0, 1'b0, 64'd3, 64'd0);
        drain();

        // Port 1 write then read back
        send(1'b1, 1'b1, 64'd7, 64'hDEAD_BEEF);
        send(1'b1, 1'b0, 64'd7, 64'd0);
        drain();

        // Contention right after reset: expect grants 0,1,0,1
        pulse_reset();
        a0 = acc_count;
        acc_ports.delete();
        drive(1'b0, 1'b1, 1'b0, 64'd1, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'd2, 64'd0);
        for (int i = 0; i < 100 && acc_count < a0 + 4; i++) @(negedge clk);
        @(posedge clk); #1;
        bus0.req0_valid = 1'b0;
        bus0.req1_valid = 1'b0;
        chk("contention_accepts", 64'(acc_count - a0), 64'd4);
        for (int i = 0; i < 4 && i < acc_ports.size(); i++)
            chk("contention_order", 64'(acc_ports[i]), 64'(i % 2));
        drain();

        // Four back-to-back port 0 writes, then read one back on port 1
        w0 = wr_edges;
        r0 = rd_strobes;
        for (int i = 0; i < 4; i++)
            send(1'b0, 1'b1, 64'(10 + i), 64'hA5A5_0000_0000_0000 + 64'(i * 17));
        drain();
        chk("b2b_wr_edges", 64'(wr_edges - w0), 64'd4);
        chk("b2b_no_read", 64'(rd_strobes - r0), 64'd0);
        send(1'b1, 1'b0, 64'd12, 64'd0);
        drain();

        // Reset during WAIT, with a new port 0 request pending across it
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 64'd3, 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = bus0.req0_ready;
        end
        chk("midrst_accept", 64'(ok), 64'd1);
        @(posedge clk);            // -> ISSUE
        @(posedge clk); #1;        // -> WAIT
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 64'd7, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = bus0.req0_ready;
        end
        chk("post_rst_accept", 64'(ok), 64'd1);
        @(posedge clk); #1 bus0.req0_valid = 1'b0;
        drain();

        // MEM_LAT=3 instance: read addr 9, response 5 cycles after accept
        @(posedge clk); #1;
        bus3.req0_valid = 1'b1; bus3.req0_we = 1'b0; bus3.req0_addr = 64'd9;
        ok = 1'b0;
        t3 = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = bus3.req0_ready;
            t3 = cyc;
        end
        chk("lat3_accept", 64'(ok), 64'd1);
        @(posedge clk); #1 bus3.req0_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = bus3.rsp0_valid;
        end
        chk("lat3_rsp_seen", 64'(ok), 64'd1);
        chk("lat3_latency", 64'(cyc - t3), 64'd5);
        chk("lat3_rdata", bus3.rsp0_rdata, 64'hC0DE_0000_0000_0009);
        chk("lat3_rsp1_idle", 64'(bus3.rsp1_valid), 64'd0);
        $display("[TB] lat3 rsp port=0 rdata=%h cycle=%0d", bus3.rsp0_rdata, cyc);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
